counter_sequencer: RTL
======================

// Module: counter_sequencer
//
// PURPOSE
//   Shares one Size-bit up-counter between NumReq requesters.
//   Each requester asks for a run of a programmed number of ticks.
//   A round-robin arbiter grants the counter to one requester at a time.
//   The FSM clears the counter, advances it once per clock up to the winner's limit,
//   pulses that winner's done bit, then releases the counter.
//   Sits between requesting blocks and the counter datapath; the Ruby-VPI bench drives it through relay points.
//
// PARAMETERS
//   Size    5  counter width in bits; limits and count are unsigned Size-bit values
//   NumReq  2  number of requesters (>= 2)
//
// PORTS
//   clock  input   1              rising-edge clock
//   reset  input   1              asynchronous, active-high reset
//   req    input   NumReq         per-requester request level; held until done or abandoned
//   limit  input   NumReq*Size    packed limits; requester i uses bits [i*Size +: Size]
//   abort  input   1              synchronous cancel of the current run
//   grant  output  NumReq         one-hot owner of the counter; all zero when idle
//   busy   output  1              high while in RUN or DONE
//   count  output  [Size-1:0]     shared counter value
//   done   output  NumReq         one-cycle completion pulse to the owner
//
// BEHAVIOUR
//   Reset (async, immediate):
//     - state=IDLE; grant=0, busy=0, count=0, done=0; round-robin pointer ptr=0.
//   IDLE:
//     - If any req bit is set, pick the first set bit searching from ptr upward, wrapping.
//     - Latch that requester's limit as lim.
//     - Next edge: grant=onehot(winner), busy=1, count=0.
//     - Next state is RUN when lim!=0, DONE when lim==0.
//   RUN:
//     - Each edge: count<=count+1.
//     - On the edge where count+1==lim, enter DONE with count=lim.
//     - The counter never wraps; lim <= 2^Size-1.
//   DONE (one cycle):
//     - done[winner]=1 and grant stays asserted.
//     - Next edge: grant=0, busy=0, done=0, ptr<=(winner+1)%NumReq, state=IDLE.
//     - count holds lim until the next grant.
//   Latency:
//     - Request is sampled in IDLE; grant appears 1 edge later.
//     - done is high during the cycle following edge 1+lim, counted from the sampling edge.
//     - IDLE is revisited for at least one cycle between runs.
//   Changes while granted:
//     - limit changes are ignored for the current run.
//     - A new req from the current owner during DONE is served only after the IDLE cycle, subject to round-robin.
//   Owner drops req in RUN:
//     - Run is abandoned; next edge: IDLE, grant=0, busy=0, count=0.
//     - No done pulse; ptr advances past the owner.
//   Owner drops req in DONE:
//     - done still pulses and completes normally.
//   abort:
//     - Highest priority after reset, in any state.
//     - Next edge: IDLE, grant=0, busy=0, done=0, count=0; ptr unchanged.
//     - abort in IDLE also suppresses arbitration that cycle.
//   Simultaneous requests:
//     - Exactly one winner per arbitration; a grant is never split.
//     - Losing requests stay pending and are not dropped.
//   Reset mid-run:
//     - All outputs return to reset values at once.
//     - No done pulse is produced.
//
// STRUCTURE
//   Shared package counter_sequencer_pkg:
//     - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//     - A onehot helper function.
//   Sub-module rr_arbiter #(NumReq):
//     - Combinational; inputs req and ptr, outputs one-hot winner and winner index.
//   Top level:
//     - FSM, lim register, counter register, ptr register.
//     - All registers on posedge clock or posedge reset.
//
// TESTING
//   1. Reset, then req=2'b01, limit0=3:
//        grant=01 one edge later; count 0,1,2,3;
//        done=01 for one cycle at count=3; then grant=00, busy=0.
//   2. req=2'b11 held, limits 2 and 4:
//        order is requester0 (done at count 2), then requester1 (done at count 4),
//        then requester0 again; ptr alternates.
//   3. limit0=0, req=01:
//        grant=01 and done=01 in the same cycle; count stays 0.
//   4. limit0=31 (Size=5):
//        count reaches 31, done pulses, and count never wraps to 0 inside the run.
//   5. abort at count=2 of a limit-6 run:
//        next edge grant=0, busy=0, count=0; no done pulse;
//        the same requester wins next if still requesting.
//   6. reset asserted mid-run, between clock edges:
//        outputs zero immediately, without waiting for an edge;
//        after release, req=10 is granted with ptr=0 search order.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM encodings and a one-hot helper.
package counter_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widest requester vector the helper can encode; callers cast down to NumReq.
    localparam int unsigned MaxReq = 32;

    function automatic logic [MaxReq-1:0] onehot(input int unsigned idx);
        logic [MaxReq-1:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_ptr, wrapping.
module rr_arbiter
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [PtrW-1:0]   i_ptr,
    output logic [NumReq-1:0] o_grant,
    output logic [PtrW-1:0]   o_idx,
    output logic              o_valid
);

    logic [PtrW-1:0] w_cand;

    // Scan candidates in priority order starting at the pointer; keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            w_cand = PtrW'((32'(i_ptr) + off) % NumReq);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
                o_grant = NumReq'(onehot(32'(w_cand)));
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Shares one up-counter among NumReq requesters; each run counts to the winner's limit.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned Size   = 5,
    parameter int unsigned NumReq = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NumReq-1:0]      req,
    input  logic [NumReq*Size-1:0] limit,
    input  logic                   abort,
    output logic [NumReq-1:0]      grant,
    output logic                   busy,
    output logic [Size-1:0]        count,
    output logic [NumReq-1:0]      done
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [1:0]        r_state;
    logic [NumReq-1:0] r_grant;
    logic [Size-1:0]   r_count;
    logic [Size-1:0]   r_lim;
    logic [PtrW-1:0]   r_ptr;
    logic [PtrW-1:0]   r_idx;

    logic [NumReq-1:0] w_arb_grant;
    logic [PtrW-1:0]   w_arb_idx;
    logic              w_arb_valid;
    logic [Size-1:0]   w_lim_sel;
    logic [Size-1:0]   w_count_inc;
    logic [PtrW-1:0]   w_ptr_next;
    logic              w_owner_req;

    rr_arbiter #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_lim_sel   = limit[w_arb_idx*Size +: Size];
    assign w_count_inc = r_count + Size'(1);
    assign w_owner_req = |(req & r_grant);
    assign w_ptr_next  = (r_idx == PtrW'(NumReq - 1)) ? '0 : r_idx + PtrW'(1);

    // Outputs decode directly from registered state, so reset clears them immediately.
    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);
    assign count = r_count;
    assign done  = (r_state == ST_DONE) ? r_grant : '0;

    // Sequencer FSM with arbitration, limit latch, counter and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_count <= '0;
            r_lim   <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else if (abort) begin
            // Cancel without moving the pointer, so the same requester may win again.
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant <= w_arb_grant;
                        r_idx   <= w_arb_idx;
                        r_lim   <= w_lim_sel;
                        r_count <= '0;
                        r_state <= (w_lim_sel != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (!w_owner_req) begin
                        // Owner abandoned the run: no done pulse, but it loses its turn.
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_count <= '0;
                        r_ptr   <= w_ptr_next;
                    end else begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_lim) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Count keeps the final value until the next grant.
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_ptr   <= w_ptr_next;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
